// File: rtl/spi_tx_engine.sv
// rtl/spi_tx_engine.sv - SPI mode-0 frame engine fed from an upstream FIFO
// Frame: FETCH, LOAD, SETUP, WIDTH bit periods in SHIFT, HOLD, then GAP with CS_N high.
module spi_tx_engine #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 4
) (
   input  logic             PCLK,
   input  logic             PRESET_N,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_rd_en,
   output logic             SCLK,
   output logic             MOSI,
   input  logic             MISO,
   output logic             CS_N,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(WIDTH) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [BW-1:0] BIT_ALL  = BW'(WIDTH);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t           state_q;
   logic [DW-1:0]    div_q;
   logic [BW-1:0]    bit_q;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] rx_shift_q;
   logic [WIDTH-1:0] rx_data_q;
   logic             rd_en_q;
   logic             sclk_q;
   logic             cs_n_q;
   logic             rx_valid_q;
   logic             div_last;

   assign div_last = (div_q == DIV_LAST);

   always_ff @(posedge PCLK) begin
      if (!PRESET_N) begin
         state_q    <= IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rd_en_q    <= 1'b0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         rx_valid_q <= 1'b0;
      end else begin
         rd_en_q    <= 1'b0;
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  rd_en_q <= 1'b1;
                  state_q <= FETCH;
               end
            end
            FETCH: state_q <= LOAD;
            LOAD: begin
               shift_q <= fifo_dout;
               cs_n_q  <= 1'b0;
               div_q   <= '0;
               state_q <= SETUP;
            end
            SETUP: begin
               if (div_last) begin
                  div_q      <= '0;
                  sclk_q     <= 1'b1;
                  rx_shift_q <= {rx_shift_q[WIDTH-2:0], MISO};
                  state_q    <= SHIFT;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            SHIFT: begin
               if (!div_last) begin
                  div_q <= div_q + 1'b1;
               end else begin
                  div_q <= '0;
                  // High half ends: SCLK falls and MOSI advances, except after the final bit.
                  if (sclk_q) begin
                     sclk_q <= 1'b0;
                     bit_q  <= bit_q + 1'b1;
                     if (bit_q != BIT_LAST) begin
                        shift_q <= {shift_q[WIDTH-2:0], 1'b0};
                     end
                  end else if (bit_q == BIT_ALL) begin
                     state_q <= HOLD;
                  end else begin
                     sclk_q     <= 1'b1;
                     rx_shift_q <= {rx_shift_q[WIDTH-2:0], MISO};
                  end
               end
            end
            HOLD: begin
               if (div_last) begin
                  div_q      <= '0;
                  bit_q      <= '0;
                  shift_q    <= '0;
                  cs_n_q     <= 1'b1;
                  rx_data_q  <= rx_shift_q;
                  rx_valid_q <= 1'b1;
                  state_q    <= GAP;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            GAP: begin
               if (div_last) begin
                  div_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fifo_rd_en = rd_en_q;
   assign SCLK       = sclk_q;
   assign MOSI       = shift_q[WIDTH-1];
   assign CS_N       = cs_n_q;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_tx_engine.sv
// tb/tb_spi_tx_engine.sv - self-checking bench for spi_tx_engine
// FIFO and SPI slave models plus a frame-level scoreboard sampled on the falling clock edge.
module tb_spi_tx_engine;
   localparam int W  = 8;
   localparam int CD = 2;
   localparam int CS_LOW_CYCLES = (2 * W + 2) * CD;

   logic         PCLK = 1'b0;
   logic         PRESET_N = 1'b0;
   logic         fifo_empty = 1'b1;
   logic [W-1:0] fifo_dout = '0;
   logic         fifo_rd_en;
   logic         SCLK;
   logic         MOSI;
   logic         MISO = 1'b0;
   logic         CS_N;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n_rd     = 0;
   int n_rxv    = 0;

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] sent_q[$];
   logic         loop_mode = 1'b1;
   logic [W-1:0] slave_word = '0;

   // monitor state
   logic         prev_cs = 1'b1;
   logic         prev_sclk = 1'b0;
   logic         prev_rd = 1'b0;
   int           since_rd = 99;
   int           cs_low_cnt = 0;
   int           cs_high_cnt = 0;
   logic         gap_valid = 1'b0;
   int           rise_cnt = 0;
   int           fall_cnt = 0;
   logic [W-1:0] mosi_word = '0;

   spi_tx_engine #(.WIDTH(W), .CLK_DIV(CD)) dut (
      .PCLK       (PCLK),
      .PRESET_N   (PRESET_N),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .SCLK       (SCLK),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .CS_N       (CS_N),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .busy       (busy)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge PCLK) begin
      logic         cs_rise, cs_fall, sclk_rise, sclk_fall;
      logic [W-1:0] exp_tx, exp_rx;
      if (!PRESET_N) begin
         sent_q.delete();
         since_rd    = 99;
         cs_low_cnt  = 0;
         cs_high_cnt = 0;
         gap_valid   = 1'b0;
         rise_cnt    = 0;
         fall_cnt    = 0;
         mosi_word   = '0;
         prev_rd     = 1'b0;
      end else begin
         cs_rise   = !prev_cs && CS_N;
         cs_fall   = prev_cs && !CS_N;
         sclk_rise = !prev_sclk && SCLK;
         sclk_fall = prev_sclk && !SCLK;

         if (fifo_rd_en) begin
            check("rd_en_single_cycle", prev_rd, 1'b0);
            check("rd_en_with_data", fifo_q.size() > 0, 1'b1);
            if (fifo_q.size() > 0) begin
               fifo_dout = fifo_q.pop_front();
               sent_q.push_back(fifo_dout);
            end
            fifo_empty = (fifo_q.size() == 0);
            n_rd++;
            since_rd = 0;
         end else if (since_rd < 99) begin
            since_rd++;
         end

         check("sclk_low_when_cs_high", SCLK & CS_N, 1'b0);
         check("rx_valid_at_cs_rise", rx_valid, cs_rise);
         if (!CS_N) check("busy_when_cs_low", busy, 1'b1);

         if (cs_fall) begin
            check("rd_to_cs_latency", since_rd, 2);
            if (gap_valid) check("cs_high_gap", cs_high_cnt >= CD + 1, 1'b1);
            rise_cnt  = 0;
            fall_cnt  = 0;
            mosi_word = '0;
         end
         if (sclk_rise) begin
            mosi_word = {mosi_word[W-2:0], MOSI};
            rise_cnt++;
         end
         if (sclk_fall) fall_cnt++;
         if (!CS_N) cs_low_cnt++;
         if (CS_N) cs_high_cnt++;

         if (cs_rise) begin
            n_rxv++;
            check("frame_has_pop", sent_q.size() > 0, 1'b1);
            exp_tx = (sent_q.size() > 0) ? sent_q.pop_front() : '0;
            exp_rx = loop_mode ? exp_tx : slave_word;
            check("cs_low_duration", cs_low_cnt, CS_LOW_CYCLES);
            check("sclk_rise_count", rise_cnt, W);
            check("mosi_frame", mosi_word, exp_tx);
            check("rx_data_frame", rx_data, exp_rx);
            cs_low_cnt  = 0;
            cs_high_cnt = 1;
            gap_valid   = 1'b1;
         end
         prev_rd = fifo_rd_en;
      end

      if (CS_N) fall_cnt = 0;
      if (loop_mode) MISO = MOSI;
      else MISO = (fall_cnt < W) ? slave_word[W-1-fall_cnt] : 1'b0;
      prev_cs   = CS_N;
      prev_sclk = SCLK;
   end

   task automatic push(input logic [W-1:0] b);
      fifo_q.push_back(b);
      fifo_empty = 1'b0;
   endtask

   task automatic wait_rx(input int target, input int budget);
      int c = 0;
      while (n_rxv < target && c < budget) begin
         @(negedge PCLK);
         c++;
      end
      check("wait_rx_timeout", n_rxv >= target, 1'b1);
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      @(negedge PCLK);
      while ((busy || !fifo_empty) && c < budget) begin
         @(negedge PCLK);
         c++;
      end
      check("wait_idle_timeout", busy, 1'b0);
   endtask

   initial begin
      int           r0, d0, cnt, rises;
      logic         ps;
      logic [W-1:0] b;

      // reset held with data waiting
      push(8'hA5);
      repeat (5) begin
         @(negedge PCLK);
         check("rst_rd_en", fifo_rd_en, 1'b0);
         check("rst_cs_n", CS_N, 1'b1);
         check("rst_sclk", SCLK, 1'b0);
         check("rst_busy", busy, 1'b0);
      end
      check("rst_mosi", MOSI, 1'b0);
      check("rst_rx_data", rx_data, '0);
      check("rst_rx_valid", rx_valid, 1'b0);

      // single frame, loopback
      @(posedge PCLK); #1;
      PRESET_N = 1'b1;
      wait_rx(1, 200);
      wait_idle(50);
      check("single_rd_count", n_rd, 1);
      check("single_rx_data", rx_data, 8'hA5);

      // back-to-back frames
      @(posedge PCLK); #1;
      push(8'h3C);
      push(8'hC3);
      wait_rx(3, 300);
      wait_idle(50);
      check("b2b_rd_count", n_rd, 3);
      check("b2b_last_rx", rx_data, 8'hC3);

      // receive path from independent slave model
      @(posedge PCLK); #1;
      loop_mode  = 1'b0;
      slave_word = 8'h5A;
      push(8'hFF);
      wait_rx(4, 200);
      wait_idle(50);
      check("rx_path_data", rx_data, 8'h5A);

      // randomized batches
      for (int k = 0; k < 8; k++) begin
         @(posedge PCLK); #1;
         loop_mode  = 1'($urandom_range(0, 1));
         slave_word = W'($urandom);
         cnt        = $urandom_range(1, 3);
         r0         = n_rxv;
         d0         = n_rd;
         for (int j = 0; j < cnt; j++) begin
            push(W'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge PCLK);
            #1;
         end
         wait_rx(r0 + cnt, 150 * cnt);
         wait_idle(60);
         check("rand_rd_count", n_rd - d0, cnt);
         repeat ($urandom_range(0, 10)) @(posedge PCLK);
      end

      // mid-frame reset at the 4th SCLK rise
      @(posedge PCLK); #1;
      loop_mode = 1'b1;
      b = W'($urandom);
      push(b);
      rises = 0;
      ps    = SCLK;
      for (int c = 0; c < 500 && rises < 4; c++) begin
         @(posedge PCLK); #1;
         if (SCLK && !ps) rises++;
         ps = SCLK;
      end
      check("midrst_reach_rise4", rises, 4);
      r0 = n_rxv;
      d0 = n_rd;
      PRESET_N = 1'b0;
      @(posedge PCLK);
      @(negedge PCLK);
      check("midrst_cs_n", CS_N, 1'b1);
      check("midrst_sclk", SCLK, 1'b0);
      check("midrst_busy", busy, 1'b0);
      @(posedge PCLK); #1;
      PRESET_N = 1'b1;
      repeat (50) @(negedge PCLK);
      check("midrst_no_refetch", n_rd, d0);
      check("midrst_no_rx_valid", n_rxv, r0);
      check("midrst_fifo_empty", fifo_empty, 1'b1);

      // empty FIFO soak
      for (int c = 0; c < 100; c++) begin
         @(negedge PCLK);
         check("empty_rd_en", fifo_rd_en, 1'b0);
         check("empty_cs_n", CS_N, 1'b1);
         check("empty_busy", busy, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_tx_engine.md
SPI_TX_ENGINE -- requirements
Module: spi_tx_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the SPI frame width in bits and the FIFO data width.
REQ-002 SHALL have parameter CLK_DIV, default 4, meaning the number of PCLK cycles per SCLK half-period; legal values are at least 2.
REQ-003 SHALL have port PCLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port PRESET_N, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port fifo_empty, input, 1 bit: the upstream APB FIFO has no data.
REQ-006 SHALL have port fifo_dout, input, WIDTH bits: upstream FIFO read data, valid in the cycle after fifo_rd_en.
REQ-007 SHALL have port fifo_rd_en, output, 1 bit: single-cycle FIFO pop request.
REQ-008 SHALL have port SCLK, output, 1 bit: SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-009 SHALL have port MOSI, output, 1 bit: serial data out, MSB first.
REQ-010 SHALL have port MISO, input, 1 bit: serial data in.
REQ-011 SHALL have port CS_N, output, 1 bit: active-low chip select, one frame per assertion.
REQ-012 SHALL have port rx_data, output, WIDTH bits: last received frame.
REQ-013 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, FETCH, LOAD, SETUP, SHIFT, HOLD, GAP.
REQ-016 IDLE: when fifo_empty=0, next state SHALL be FETCH; otherwise the block SHALL stay in IDLE.
REQ-017 FETCH: fifo_rd_en SHALL be 1 for exactly this one cycle; next state SHALL be LOAD.
REQ-018 fifo_rd_en SHALL never be asserted outside FETCH; FETCH SHALL only be entered with fifo_empty=0.
REQ-019 LOAD: the shift register SHALL capture fifo_dout; next state SHALL be SETUP.
REQ-020 SETUP: CS_N=0, SCLK=0, and MOSI = shift-register MSB, for CLK_DIV cycles; next state SHALL be SHIFT.
REQ-021 SHIFT timing: WIDTH bits, each one SCLK-high half-period followed by one SCLK-low half-period, for 2*WIDTH*CLK_DIV cycles in total.
REQ-022 SHIFT sampling: MISO SHALL be sampled into the receive register LSB on the PCLK edge where SCLK rises.
REQ-023 SHIFT output: MOSI SHALL advance to the next bit on the edge where SCLK falls, except after the last bit.
REQ-024 A half-period counter SHALL count modulo CLK_DIV; a bit counter of width clog2(WIDTH)+1 SHALL count completed bits.
REQ-025 After the WIDTH-th SCLK fall, the block SHALL enter HOLD: CS_N=0 and SCLK=0 for CLK_DIV cycles.
REQ-026 GAP: CS_N=1; in the first GAP cycle rx_data SHALL take the received frame and rx_valid SHALL be 1 for that cycle only; GAP lasts CLK_DIV cycles, then IDLE.
REQ-027 Back-to-back frames: IDLE SHALL be held for at least 1 cycle, so CS_N stays high for at least CLK_DIV+1 cycles between frames.
REQ-028 fifo_empty SHALL be ignored outside IDLE.
REQ-029 Per-frame latency from fifo_rd_en to the first-cycle CS_N=0 SHALL be 2 cycles; CS_N low duration SHALL be (2*WIDTH+2)*CLK_DIV cycles.
REQ-030 SCLK SHALL be 0 whenever CS_N=1.

Reset
REQ-031 With PRESET_N=0 at a PCLK edge, state SHALL go to IDLE, and on the next edge the outputs SHALL be: fifo_rd_en=0, SCLK=0, MOSI=0, CS_N=1, rx_data=0, rx_valid=0, busy=0, with all counters at 0.
REQ-032 Reset mid-frame SHALL abort the frame: the popped byte is discarded, no rx_valid is produced, and the byte is not re-fetched.
REQ-033 Reset SHALL take priority over every state transition; there SHALL be no asynchronous path from PRESET_N.

Verification
REQ-034 Reset: hold PRESET_N=0 for 5 cycles with fifo_empty=0 -> fifo_rd_en=0, CS_N=1, SCLK=0, busy=0 throughout.
REQ-035 Single frame: WIDTH=8, CLK_DIV=2, fifo_dout=0xA5, MISO looped to MOSI -> MOSI=1,0,1,0,0,1,0,1 on 8 SCLK rises, CS_N low for 36 cycles, rx_data=0xA5, rx_valid high 1 cycle.
REQ-036 Back-to-back: FIFO holds 0x3C then 0xC3 -> exactly two 1-cycle fifo_rd_en pulses, CS_N high for at least 3 cycles between frames, two rx_valid pulses with 0x3C then 0xC3.
REQ-037 Receive path: MISO driven from 0x5A by an independent model, MOSI=0xFF -> rx_data=0x5A.
REQ-038 Mid-frame reset: assert PRESET_N=0 at the 4th SCLK rise -> CS_N=1 on the next cycle, no rx_valid, and with fifo_empty=1 afterward no further fifo_rd_en.
REQ-039 Empty FIFO: hold fifo_empty=1 for 100 cycles -> fifo_rd_en=0, CS_N=1, busy=0 throughout.
